// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//
// Registered WIDTH-bit full adder. It computes {Cout, Sum} = A + B + Cin
// through an explicit ripple-carry chain and registers the result, so the
// latency is exactly one clock. There is no combinational path from any input
// to any output. A valid qualifier travels alongside the data, so the cell can
// accept a new operand set on every clock.
//
// Parameters:
//   WIDTH      operand and sum width in bits (legal range 1..64, default 1)
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset (wins over in_valid)
//   in_valid   in   1      qualifies A/B/Cin this cycle
//   A          in   WIDTH  unsigned operand A
//   B          in   WIDTH  unsigned operand B
//   Cin        in   1      carry-in
//   Sum        out  WIDTH  registered sum
//   Cout       out  1      registered carry-out
//   out_valid  out  1      Sum/Cout were produced from a valid input last cycle
//   ovf        out  1      registered two's-complement overflow flag
//                          (present only when FULL_ADDER_OVERFLOW_EN is defined)
//
// Optional feature macro: FULL_ADDER_OVERFLOW_EN
// -----------------------------------------------------------------------------
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             out_valid
`ifdef FULL_ADDER_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    // Carry chain: w_carry[0] is Cin and w_carry[WIDTH] is the carry-out.
    // Holding the whole chain in one vector keeps the carry into the MSB
    // (w_carry[WIDTH-1]) available, which the overflow flag needs.
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_prop;

    assign w_carry[0] = Cin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign w_prop[gi]      = A[gi] ^ B[gi];
            assign w_sum[gi]       = w_prop[gi] ^ w_carry[gi];
            assign w_carry[gi + 1] = (A[gi] & B[gi]) | (w_carry[gi] & w_prop[gi]);
        end
    endgenerate

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_valid;

    // Data registers load only on valid cycles, so whatever sits on A/B/Cin
    // while in_valid is low (including X/Z) never reaches the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_carry[WIDTH];
            end
        end
    end

    assign Sum       = r_sum;
    assign Cout      = r_cout;
    assign out_valid = r_valid;

`ifdef FULL_ADDER_OVERFLOW_EN
    // Signed overflow occurs when the carry into the MSB differs from the
    // carry out of it. For WIDTH=1 this reduces to Cout ^ Cin.
    logic w_ovf;
    logic r_ovf;

    assign w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (in_valid) begin
            r_ovf <= w_ovf;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
//
// Drives a WIDTH=1 and a WIDTH=8 instance of full_adder side by side. Each
// cycle the stimulus process computes the expected registered state from plain
// integer arithmetic and pushes it onto a per-instance queue; an independent
// monitor pops one entry per cycle on the falling edge and compares it with
// the outputs.
// -----------------------------------------------------------------------------
module tb_full_adder;

    typedef struct {
        logic        valid;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;

    logic       v1, a1, b1, c1;
    logic [0:0] sum1;
    logic       cout1, ov1;

    logic       v8, c8;
    logic [7:0] a8, b8, sum8;
    logic       cout8, ov8;

`ifdef FULL_ADDER_OVERFLOW_EN
    logic       ovf1, ovf8;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    exp_t q1[$];
    exp_t q8[$];
    exp_t m1, m8;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .A         (a1),
        .B         (b1),
        .Cin       (c1),
        .Sum       (sum1),
        .Cout      (cout1),
        .out_valid (ov1)
`ifdef FULL_ADDER_OVERFLOW_EN
        ,
        .ovf       (ovf1)
`endif
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v8),
        .A         (a8),
        .B         (b8),
        .Cin       (c8),
        .Sum       (sum8),
        .Cout      (cout8),
        .out_valid (ov8)
`ifdef FULL_ADDER_OVERFLOW_EN
        ,
        .ovf       (ovf8)
`endif
    );

    // Reference: unsigned sum at 65 bits for Sum/Cout, signed-range test for
    // overflow, and "keep last result" on invalid cycles.
    function automatic exp_t model(input int w, input exp_t prev, input logic r,
                                   input logic v, input logic [63:0] a_in,
                                   input logic [63:0] b_in, input logic cin);
        exp_t        e;
        logic [63:0] mask;
        logic [63:0] a;
        logic [63:0] b;
        logic [64:0] full;
        longint      sa, sb, s, lim;
        mask = (64'd1 << w) - 64'd1;
        if (r) begin
            e.valid = 1'b0; e.sum = '0; e.cout = 1'b0; e.ovf = 1'b0;
        end else if (v) begin
            a    = a_in & mask;
            b    = b_in & mask;
            full = {1'b0, a} + {1'b0, b} + 65'(cin);
            e.valid = 1'b1;
            e.sum   = full[63:0] & mask;
            e.cout  = full[w];
            lim = longint'(1) << (w - 1);
            sa  = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
            sb  = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
            s   = sa + sb + longint'(cin);
            e.ovf = (s >= lim) || (s < -lim);
        end else begin
            e = prev;
            e.valid = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus for both instances; invalid cycles drive X on data.
    task automatic cyc(input logic r,
                       input logic va, input logic aa, input logic ba, input logic ca,
                       input logic vb, input logic [7:0] ab, input logic [7:0] bb,
                       input logic cb);
        @(negedge clk);
        rst = r;
        v1 = va; a1 = va ? aa : 1'bx; b1 = va ? ba : 1'bx; c1 = va ? ca : 1'bx;
        v8 = vb; a8 = vb ? ab : 8'hxx; b8 = vb ? bb : 8'hxx; c8 = vb ? cb : 1'bx;
        @(posedge clk);
        m1 = model(1, m1, r, va, {63'd0, aa}, {63'd0, ba}, ca);
        m8 = model(8, m8, r, vb, {56'd0, ab}, {56'd0, bb}, cb);
        q1.push_back(m1);
        q8.push_back(m8);
        $display("txn t=%0t rst=%0b | w1 v=%0b %0b+%0b+%0b -> %0b%0b | w8 v=%0b %h+%h+%0b -> %0b_%h",
                 $time, r, va, aa, ba, ca, m1.cout, m1.sum[0], vb, ab, bb, cb, m8.cout, m8.sum[7:0]);
    endtask

    task automatic rnd_cyc(input logic r, input logic va, input logic vb);
        logic [7:0] x, y;
        logic [2:0] t;
        x = 8'($urandom);
        y = 8'($urandom);
        t = 3'($urandom);
        cyc(r, va, t[0], t[1], t[2], vb, x, y, x[0] ^ y[7]);
    endtask

    // Monitor: one expected entry per clock, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("w1.out_valid", {63'd0, ov1}, {63'd0, e.valid});
                chk("w1.sum", {63'd0, sum1}, e.sum);
                chk("w1.cout", {63'd0, cout1}, {63'd0, e.cout});
`ifdef FULL_ADDER_OVERFLOW_EN
                chk("w1.ovf", {63'd0, ovf1}, {63'd0, e.ovf});
`endif
            end
            if (q8.size() > 0) begin
                e = q8.pop_front();
                chk("w8.out_valid", {63'd0, ov8}, {63'd0, e.valid});
                chk("w8.sum", {56'd0, sum8}, e.sum);
                chk("w8.cout", {63'd0, cout8}, {63'd0, e.cout});
`ifdef FULL_ADDER_OVERFLOW_EN
                chk("w8.ovf", {63'd0, ovf8}, {63'd0, e.ovf});
`endif
            end
        end
    end

    initial begin
        logic [2:0] bits;
        rst = 1'b1;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        v8 = 1'b0; a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
        m1 = '{1'b0, 64'd0, 1'b0, 1'b0};
        m8 = '{1'b0, 64'd0, 1'b0, 1'b0};

        // Reset state.
        cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);
        cyc(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);

        // Exhaustive single-bit table, 000..111 back to back.
        for (int i = 0; i < 8; i++) begin
            bits = 3'(i);
            cyc(0, 1, bits[2], bits[1], bits[0], 1, 8'(i * 37), 8'(i * 91), bits[0]);
        end

        // Reset beats a simultaneous valid input, then 1+1+1 after release.
        cyc(1, 1, 1, 1, 1, 1, 8'hFF, 8'hFF, 1);
        cyc(0, 1, 1, 1, 1, 1, 8'hFF, 8'hFF, 1);

        // Hold: valid 1+0+0, then invalid cycles with other data present.
        cyc(0, 1, 1, 0, 0, 1, 8'h3C, 8'h0F, 0);
        cyc(0, 0, 1, 1, 1, 0, 8'hFF, 8'hFF, 1);
        cyc(0, 0, 1, 1, 1, 0, 8'hFF, 8'hFF, 1);

        // Eight-bit carry-chain and overflow corners.
        cyc(0, 1, 1, 0, 1, 1, 8'hFF, 8'h00, 1);
        cyc(0, 1, 1, 1, 1, 1, 8'hFF, 8'hFF, 1);
        cyc(0, 1, 0, 0, 0, 1, 8'h3C, 8'h0F, 0);
        cyc(0, 1, 0, 0, 1, 1, 8'h7F, 8'h01, 0);
        cyc(0, 1, 1, 1, 0, 1, 8'h80, 8'h80, 0);
        cyc(0, 1, 0, 1, 1, 1, 8'h01, 8'h01, 0);
        cyc(0, 1, 0, 0, 0, 1, 8'h00, 8'h00, 0);

        // Back-to-back random valid stream.
        for (int i = 0; i < 1000; i++) rnd_cyc(0, 1, 1);

        // Random valid gaps and occasional mid-stream reset.
        for (int i = 0; i < 300; i++)
            rnd_cyc(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom));

        cyc(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0);

        // Bounded drain of the scoreboard.
        repeat (4) @(negedge clk);
        n_cmp++;
        if (q1.size() != 0 || q8.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d/%0d entries left, expected 0/0", q1.size(), q8.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered full adder: adds operands A and B plus carry-in Cin, producing Sum and carry-out Cout one clock after the inputs are sampled.
- WIDTH-parameterised. WIDTH=1 is the classic single-bit full adder cell, which is the default and the primary use.
- Leaf arithmetic cell for ripple/accumulator datapaths. It carries a simple valid qualifier so it can sit in a pipelined stream.

Parameters:
- WIDTH, 1, operand and sum width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies A/B/Cin this cycle.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- Cin  input  1  carry-in.
- Sum  output  WIDTH  registered sum bits.
- Cout  output  1  registered carry-out.
- out_valid  output  1  Sum/Cout hold a result computed from a valid input.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: when rst=1 at a posedge, Sum=0, Cout=0 and out_valid=0 after that edge. Reset has priority over in_valid in the same cycle.
- Reset mid-stream discards any result being computed; the first valid input after rst is deasserted produces out_valid one cycle later.
- Arithmetic: {Cout, Sum} = A + B + Cin, computed at WIDTH+1 bits with no truncation before the carry is extracted.
- Per bit i: s_i = a_i ^ b_i ^ c_i and c_{i+1} = (a_i & b_i) | (c_i & (a_i ^ b_i)), with c_0 = Cin and Cout = c_WIDTH.
- Sum/Cout register only. No combinational input-to-output path.
- Latency: exactly 1 clock.
- If in_valid=1 at posedge N, then after posedge N: Sum/Cout = the result of the inputs sampled at N, and out_valid=1.
- If in_valid=0 at a posedge: Sum/Cout hold their previous values and out_valid=0.
- Throughput: one result per clock; back-to-back valid inputs are allowed every cycle.
- No backpressure and no ready signal. Downstream must accept a result in the cycle out_valid=1.
- Boundaries:
  - All-ones + all-ones + Cin=1 gives Sum = all-ones, Cout=1.
  - All-zero inputs with Cin=0 give Sum=0, Cout=0.
  - Carry propagates fully, e.g. A = all-ones, B=0, Cin=1 gives Sum=0, Cout=1.
- X/Z on inputs while in_valid=0 must not affect outputs.

Optional Feature:
- Macro FULL_ADDER_OVERFLOW_EN.
- When defined: adds output port ovf (output, 1 bit), a registered two's-complement overflow flag.
  - ovf = c_WIDTH ^ c_{WIDTH-1}; for WIDTH=1 this is Cout ^ Cin.
  - Same timing and hold rules as Sum: reset to 0, updated only on valid cycles.
- When not defined: the port is absent, and the port list and behaviour are exactly as above.

Test Plan:
- Exhaustive WIDTH=1: apply all 8 {A,B,Cin} combinations 000..111 with in_valid=1, one per cycle -> one cycle later the expected {Cout,Sum} sequence is 00,01,01,10,01,10,10,11.
- Reset: drive A=1, B=1, Cin=1, in_valid=1 and assert rst in the same cycle -> Sum=0, Cout=0, out_valid=0 after the edge. Deassert rst -> the next valid 1,1,1 gives Sum=1, Cout=1.
- Hold: valid 1,0,0 then in_valid=0 with inputs 1,1,1 -> Sum=1, Cout=0 persists and out_valid drops to 0.
- WIDTH=8 carry chain: A=0xFF, B=0x00, Cin=1 -> Sum=0x00, Cout=1. A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Cout=1. A=0x3C, B=0x0F, Cin=0 -> Sum=0x4B, Cout=0.
- Back-to-back: 1000 random valid cycles at WIDTH=8 -> each output equals the reference sum of the inputs from the prior cycle, with out_valid continuously 1.
- FULL_ADDER_OVERFLOW_EN, WIDTH=8:
  - A=0x7F, B=0x01, Cin=0 -> Sum=0x80, ovf=1, Cout=0.
  - A=0x80, B=0x80, Cin=0 -> Sum=0x00, ovf=1, Cout=1.
  - A=0x01, B=0x01, Cin=0 -> ovf=0.
